// File: rtl/multi_channel_pipe_reg.sv
// Elastic NCH-lane register pipeline of DEPTH stages: one shared valid/ready handshake, bubble collapse.
// Latency DEPTH cycles, 1 word/cycle; a stalled tail backs up stage by stage, and in_ready ripples from out_ready.
module multi_channel_pipe_reg #(
    parameter int NCH   = 2,
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NCH*WIDTH-1:0]         in_data,
    input  logic [NCH-1:0]               in_mask,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NCH*WIDTH-1:0]         out_data,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);
    localparam int DW = NCH * WIDTH;
    localparam int OW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] v_q, v_d;
    logic [DW-1:0]    d_q [DEPTH];
    logic [DW-1:0]    d_d [DEPTH];
    logic [DEPTH-1:0] rdy;
    logic [DEPTH-1:0] src_v;
    logic [DW-1:0]    src_d [DEPTH];
    logic [DW-1:0]    masked;
    logic             acc;

    always_comb begin
        masked = '0;
        for (int i = 0; i < NCH; i++) begin
            masked[i*WIDTH +: WIDTH] = in_mask[i] ? in_data[i*WIDTH +: WIDTH] : '0;
        end
    end

    // A stage may load when it, or any stage downstream of it, is empty, or the sink is taking.
    always_comb begin
        rdy = '0;
        acc = out_ready;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            acc    = acc | ~v_q[k];
            rdy[k] = acc;
        end
    end

    always_comb begin
        src_v    = '0;
        src_v[0] = in_valid;
        src_d[0] = masked;
        for (int k = 1; k < DEPTH; k++) begin
            src_v[k] = v_q[k-1];
            src_d[k] = d_q[k-1];
        end
    end

    always_comb begin
        v_d = v_q;
        d_d = d_q;
        if (clr) begin
            v_d = '0;
            for (int k = 0; k < DEPTH; k++) begin
                d_d[k] = '0;
            end
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (rdy[k]) begin
                    v_d[k] = src_v[k];
                    if (src_v[k]) begin
                        d_d[k] = src_d[k];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                d_q[k] <= '0;
            end
        end else begin
            v_q <= v_d;
            for (int k = 0; k < DEPTH; k++) begin
                d_q[k] <= d_d[k];
            end
        end
    end

    always_comb begin
        occupancy = '0;
        for (int k = 0; k < DEPTH; k++) begin
            occupancy = occupancy + OW'(v_q[k]);
        end
    end

    // The flush cycle must not look like a transfer on either side.
    assign in_ready  = rdy[0] & ~clr;
    assign out_valid = v_q[DEPTH-1] & ~clr;
    assign out_data  = d_q[DEPTH-1];

endmodule

// File: tb/tb_multi_channel_pipe_reg.sv
// Bench for multi_channel_pipe_reg: directed cycle table, mid-stream reset, and randomized run against a queue model.
module tb_multi_channel_pipe_reg;
    localparam int NCH   = 2;
    localparam int WIDTH = 8;
    localparam int DEPTH = 2;
    localparam int DW    = NCH * WIDTH;
    localparam int OW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clr;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [NCH-1:0] in_mask;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [OW-1:0] occupancy;

    int n_chk  = 0;
    int n_fail = 0;

    multi_channel_pipe_reg #(.NCH(NCH), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mask   (in_mask),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] apply_mask(input logic [DW-1:0] d, input logic [NCH-1:0] m);
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < NCH; i++) begin
            if (m[i]) r[i*WIDTH +: WIDTH] = d[i*WIDTH +: WIDTH];
        end
        return r;
    endfunction

    typedef struct {
        logic          clr;
        logic          iv;
        logic [DW-1:0] dat;
        logic [NCH-1:0] msk;
        logic          ordy;
        logic          e_ir;
        logic          e_ov;
        logic [OW-1:0] e_occ;
        logic          cd;
        logic [DW-1:0] e_dat;
    } vec_t;

    function automatic vec_t mk(input logic c, input logic iv, input logic [DW-1:0] dat,
                                input logic [NCH-1:0] msk, input logic ordy, input logic e_ir,
                                input logic e_ov, input logic [OW-1:0] e_occ, input logic cd,
                                input logic [DW-1:0] e_dat);
        vec_t v;
        v.clr = c; v.iv = iv; v.dat = dat; v.msk = msk; v.ordy = ordy;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_occ = e_occ; v.cd = cd; v.e_dat = e_dat;
        return v;
    endfunction

    vec_t tbl[21];

    logic [DW-1:0] q[$];
    int            gap;
    logic          acc_x, emit_x;

    initial begin
        //                clr iv  data      msk   ordy ir   ov   occ cd  exp data
        // stream
        tbl[0]  = mk(1'b0,1'b1,16'hA1B2,2'b11,1'b1,1'b1,1'b0,2'd0,1'b0,16'h0000);
        tbl[1]  = mk(1'b0,1'b1,16'hC3D4,2'b11,1'b1,1'b1,1'b0,2'd1,1'b0,16'h0000);
        tbl[2]  = mk(1'b0,1'b0,16'h0000,2'b11,1'b1,1'b1,1'b1,2'd2,1'b1,16'hA1B2);
        tbl[3]  = mk(1'b0,1'b0,16'h0000,2'b11,1'b1,1'b1,1'b1,2'd1,1'b1,16'hC3D4);
        tbl[4]  = mk(1'b0,1'b0,16'h0000,2'b11,1'b1,1'b1,1'b0,2'd0,1'b0,16'h0000);
        // backpressure
        tbl[5]  = mk(1'b0,1'b1,16'h1111,2'b11,1'b0,1'b1,1'b0,2'd0,1'b0,16'h0000);
        tbl[6]  = mk(1'b0,1'b1,16'h2222,2'b11,1'b0,1'b1,1'b0,2'd1,1'b0,16'h0000);
        tbl[7]  = mk(1'b0,1'b1,16'h3333,2'b11,1'b0,1'b0,1'b1,2'd2,1'b1,16'h1111);
        tbl[8]  = mk(1'b0,1'b1,16'h3333,2'b11,1'b0,1'b0,1'b1,2'd2,1'b1,16'h1111);
        tbl[9]  = mk(1'b0,1'b1,16'h3333,2'b11,1'b1,1'b1,1'b1,2'd2,1'b1,16'h1111);
        tbl[10] = mk(1'b0,1'b0,16'h0000,2'b11,1'b1,1'b1,1'b1,2'd2,1'b1,16'h2222);
        tbl[11] = mk(1'b0,1'b0,16'h0000,2'b11,1'b1,1'b1,1'b1,2'd1,1'b1,16'h3333);
        tbl[12] = mk(1'b0,1'b0,16'h0000,2'b11,1'b1,1'b1,1'b0,2'd0,1'b0,16'h0000);
        // lane mask
        tbl[13] = mk(1'b0,1'b1,16'hFF5A,2'b01,1'b1,1'b1,1'b0,2'd0,1'b0,16'h0000);
        tbl[14] = mk(1'b0,1'b0,16'h0000,2'b11,1'b1,1'b1,1'b0,2'd1,1'b0,16'h0000);
        tbl[15] = mk(1'b0,1'b0,16'h0000,2'b11,1'b1,1'b1,1'b1,2'd1,1'b1,16'h005A);
        // flush with a full pipe
        tbl[16] = mk(1'b0,1'b1,16'h7777,2'b11,1'b0,1'b1,1'b0,2'd0,1'b0,16'h0000);
        tbl[17] = mk(1'b0,1'b1,16'h8888,2'b11,1'b0,1'b1,1'b0,2'd1,1'b0,16'h0000);
        tbl[18] = mk(1'b0,1'b0,16'h0000,2'b11,1'b0,1'b0,1'b1,2'd2,1'b1,16'h7777);
        tbl[19] = mk(1'b1,1'b1,16'h9999,2'b11,1'b1,1'b0,1'b0,2'd2,1'b0,16'h0000);
        tbl[20] = mk(1'b0,1'b0,16'h0000,2'b11,1'b0,1'b1,1'b0,2'd0,1'b1,16'h0000);

        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; in_mask = '1; out_ready = 1'b0;
        #12;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_occupancy", 32'(occupancy), 32'd0);
        chk("reset_out_data",  32'(out_data),  32'd0);
        chk("reset_in_ready",  32'(in_ready),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            @(posedge clk); #1;
            clr = tbl[i].clr; in_valid = tbl[i].iv; in_data = tbl[i].dat;
            in_mask = tbl[i].msk; out_ready = tbl[i].ordy;
            @(negedge clk);
            chk($sformatf("row%0d_in_ready", i),  32'(in_ready),  32'(tbl[i].e_ir));
            chk($sformatf("row%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
            chk($sformatf("row%0d_occupancy", i), 32'(occupancy), 32'(tbl[i].e_occ));
            if (tbl[i].cd)
                chk($sformatf("row%0d_out_data", i), 32'(out_data), 32'(tbl[i].e_dat));
        end

        // mid-stream asynchronous reset
        @(posedge clk); #1;
        clr = 1'b0; in_valid = 1'b1; in_data = 16'h4242; in_mask = '1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_data = 16'h4343;
        @(posedge clk); #2;
        in_valid = 1'b0;
        chk("prefill_occupancy", 32'(occupancy), 32'd2);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_occupancy", 32'(occupancy), 32'd0);
        chk("midrst_out_data",  32'(out_data),  32'd0);
        chk("midrst_in_ready",  32'(in_ready),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // randomized traffic against an order-preserving queue model
        q.delete();
        gap = 0;
        for (int c = 0; c < 10000; c++) begin
            @(posedge clk); #1;
            clr       = ($urandom_range(0, 49) == 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            in_data   = DW'($urandom);
            in_mask   = NCH'($urandom);
            out_ready = ($urandom_range(0, 9) < 6);
            @(negedge clk);
            chk("rnd_occupancy", 32'(occupancy), 32'(q.size()));
            chk("rnd_occ_bound", 32'(occupancy <= DEPTH), 32'd1);
            chk("rnd_in_ready", 32'(in_ready),
                32'(!clr && (q.size() < DEPTH || out_ready)));
            if (clr || q.size() == 0) begin
                chk("rnd_out_valid_idle", 32'(out_valid), 32'd0);
            end else if (out_valid) begin
                chk("rnd_out_data", 32'(out_data), 32'(q[0]));
            end
            gap = (q.size() > 0 && !out_valid && !clr) ? gap + 1 : 0;
            chk("rnd_head_progress", 32'(gap < DEPTH), 32'd1);
            acc_x  = in_valid & in_ready;
            emit_x = out_valid & out_ready;
            if (clr) begin
                q.delete();
            end else begin
                if (emit_x && q.size() > 0) void'(q.pop_front());
                if (acc_x) q.push_back(apply_mask(in_data, in_mask));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
